vx_mem_line_packer: RTL and testbench

Upstream feeder for the testbench memory loader. Accepts a stream of 32-bit instruction words from the program driver and packs them into 512-bit cachelines, word 0 in bits [31:0]. Presents each completed line on the slave side of `VX_mem_load_if`, where the loader writes it into the memory model at consecutive line addresses. A one-line output register decouples assembly from the loader handshake, so filling continues while a finished line waits.

---
 rtl/vx_mem_line_packer.sv | 123 ++++++++++++
 tb/tb_vx_mem_line_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_line_packer.sv
// Packs 32-bit instruction words into cachelines for the memory loader.
// Build option VX_MEM_PACKER_PAD_NOP_EN: pad partial lines with NOP, else zero.
module vx_mem_line_packer #(
  parameter int WORD_WIDTH     = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  load_valid,
  output logic [LINE_WIDTH-1:0] cacheline,
  input  logic                  load_ready,
  output logic [CNT_WIDTH-1:0]  lines_sent,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W =
    (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(WORDS_PER_LINE - 1);

`ifdef VX_MEM_PACKER_PAD_NOP_EN
  localparam logic [WORD_WIDTH-1:0] PAD = WORD_WIDTH'(32'h00000013);
`else
  localparam logic [WORD_WIDTH-1:0] PAD = '0;
`endif

  logic [LINE_WIDTH-1:0] r_asm;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_asm_full;
  logic                  r_asm_last;
  logic [LINE_WIDTH-1:0] r_out;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_done;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_close;
  logic                  w_out_free;
  logic [LINE_WIDTH-1:0] w_line;

  assign w_in_fire  = in_valid && !r_asm_full;
  assign w_out_fire = r_out_valid && load_ready;
  assign w_close    = w_in_fire && (in_last || (r_idx == LAST_IDX));
  assign w_out_free = !r_out_valid || w_out_fire;

  // Closing line: held words, the closing word, then padding above it.
  always_comb begin
    w_line = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (i < int'(r_idx))
        w_line[i*WORD_WIDTH +: WORD_WIDTH] = r_asm[i*WORD_WIDTH +: WORD_WIDTH];
      else if (i == int'(r_idx))
        w_line[i*WORD_WIDTH +: WORD_WIDTH] = in_word;
      else
        w_line[i*WORD_WIDTH +: WORD_WIDTH] = PAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_asm       <= '0;
      r_idx       <= '0;
      r_asm_full  <= 1'b0;
      r_asm_last  <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (w_close) begin
          r_idx <= '0;
          if (w_out_free) begin
            r_out       <= w_line;
            r_out_valid <= 1'b1;
            r_out_last  <= in_last;
          end else begin
            r_asm      <= w_line;
            r_asm_full <= 1'b1;
            r_asm_last <= in_last;
          end
        end else begin
          r_asm[r_idx*WORD_WIDTH +: WORD_WIDTH] <= in_word;
          r_idx <= r_idx + 1'b1;
        end
      end
      // A line parked in the assembly buffer moves out on the next transfer.
      if (!(w_close && w_out_free)) begin
        if (r_asm_full && w_out_fire) begin
          r_out      <= r_asm;
          r_out_last <= r_asm_last;
          r_asm_full <= 1'b0;
        end else if (w_out_fire) begin
          r_out_valid <= 1'b0;
        end
      end
      if (w_out_fire)
        r_cnt <= r_cnt + 1'b1;
      if (w_out_fire && r_out_last && !r_asm_full)
        r_done <= 1'b1;
      else if (w_in_fire)
        r_done <= 1'b0;
    end
  end

  assign in_ready   = !r_asm_full;
  assign load_valid = r_out_valid;
  assign cacheline  = r_out;
  assign lines_sent = r_cnt;
  assign done       = r_done;
  assign busy       = (r_idx != '0) || r_asm_full || r_out_valid;

endmodule

// File: tb/tb_vx_mem_line_packer.sv
// Bench for vx_mem_line_packer: word-level model feeds a line scoreboard.
// Table rows cover streaming cases; hand sequences cover stalls and reset.
module tb_vx_mem_line_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_word;
  logic         in_last;
  logic         in_ready;
  logic         load_valid;
  logic [511:0] cacheline;
  logic         load_ready;
  logic [15:0]  lines_sent;
  logic         busy;
  logic         done;

  vx_mem_line_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .load_valid (load_valid),
    .cacheline  (cacheline),
    .load_ready (load_ready),
    .lines_sent (lines_sent),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

`ifdef VX_MEM_PACKER_PAD_NOP_EN
  localparam logic [31:0] PAD = 32'h00000013;
`else
  localparam logic [31:0] PAD = 32'h0;
`endif

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  logic [31:0]  m_w [16];
  int           m_idx = 0;
  logic [511:0] q [$];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: every transfer must match the oldest pushed line.
  always @(negedge clk) begin
    if (reset === 1'b1 && in_valid && !in_ready) stalls++;
    if (reset === 1'b1 && load_valid && load_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_line: got %0h expected none", cacheline);
      end else begin
        chk("line", cacheline, q.pop_front());
      end
    end
  end

  task automatic model_word(input logic [31:0] w, input bit last);
    logic [511:0] ln;
    m_w[m_idx] = w;
    if (m_idx == 15 || last) begin
      for (int i = 0; i < 16; i++)
        ln[i*32 +: 32] = (i <= m_idx) ? m_w[i] : PAD;
      q.push_back(ln);
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word fires.
  task automatic send(input logic [31:0] w, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) chk("send_timeout", 1, 0);
    else model_word(w, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          nw;
    bit          last;
    logic [31:0] base;
    int          nlines;
    bit          dn;
  } vec_t;

  vec_t         v [5];
  logic [15:0]  start;
  logic [511:0] hold;

  initial begin
    v[0] = '{16, 1'b0, 32'h2000F133, 1, 1'b0};
    v[1] = '{3,  1'b1, 32'hA0000000, 1, 1'b1};
    v[2] = '{64, 1'b0, 32'h10000000, 4, 1'b0};
    v[3] = '{1,  1'b1, 32'h55AA0000, 1, 1'b1};
    v[4] = '{17, 1'b1, 32'h77000000, 2, 1'b1};

    reset      = 1'b0;
    in_valid   = 1'b0;
    in_word    = '0;
    in_last    = 1'b0;
    load_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_cacheline", cacheline, 0);
    chk("rst_lines_sent", lines_sent, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    load_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      start  = lines_sent;
      stalls = 0;
      for (int i = 0; i < v[r].nw; i++)
        send(v[r].base + 32'(i), v[r].last && (i == v[r].nw - 1));
      chk($sformatf("r%0d_latency", r), load_valid, 1);
      drain();
      chk($sformatf("r%0d_lines", r), lines_sent, start + 16'(v[r].nlines));
      chk($sformatf("r%0d_done", r), done, v[r].dn);
      chk($sformatf("r%0d_busy", r), busy, 0);
      chk($sformatf("r%0d_no_stall", r), stalls, 0);
    end

    // Backpressure: line 0 parked in output, line 1 in assembly buffer.
    start      = lines_sent;
    load_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(32'h30000000 + 32'(i), 1'b0);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_load_valid", load_valid, 1);
    chk("bp_line0", cacheline, q[0]);
    hold = cacheline;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stable", cacheline, hold);
    chk("bp_still_low", in_ready, 0);
    chk("bp_no_sent", lines_sent, start);
    load_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_rise", in_ready, 1);
    chk("bp_sent1", lines_sent, start + 16'd1);
    @(posedge clk);
    #1;
    chk("bp_sent2", lines_sent, start + 16'd2);
    for (int i = 32; i < 40; i++) send(32'h30000000 + 32'(i), i == 39);
    drain();
    chk("bp_sent3", lines_sent, start + 16'd3);
    chk("bp_done", done, 1);

    // Reset in the middle of a line discards everything.
    for (int i = 0; i < 7; i++) send(32'h40000000 + 32'(i), 1'b0);
    chk("mid_busy", busy, 1);
    chk("mid_done_clr", done, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_idx = 0;
    q.delete();
    chk("mr_in_ready", in_ready, 1);
    chk("mr_load_valid", load_valid, 0);
    chk("mr_cacheline", cacheline, 0);
    chk("mr_lines_sent", lines_sent, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    for (int i = 0; i < 16; i++) send(32'h50000000 + 32'(i), 1'b0);
    drain();
    chk("mr_after_line", lines_sent, 1);

    // Counter wrap.
    force dut.r_cnt = 16'hFFFF;
    #1;
    release dut.r_cnt;
    chk("wrap_preload", lines_sent, 16'hFFFF);
    for (int i = 0; i < 16; i++) send(32'h60000000 + 32'(i), 1'b0);
    drain();
    chk("wrap_zero", lines_sent, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
